ps2_frame_receiver: RTL

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: synchronizes and deglitches the PS/2 clock,
// deserializes 11-bit frames and reports good bytes or framing errors.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_d;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          fall;
  logic          timeout;

  // Two-flop synchronizers; both lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= kbd_clk;
      clk_s2  <= clk_s1;
      data_s1 <= kbd_data;
      data_s2 <= data_s1;
    end
  end

  // Level flips once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = filt_d & ~filt_clk;
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign busy    = (state != IDLE);

  // Inter-edge watchdog, only running inside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == IDLE || fall) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM with registered one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      scan_code   <= '0;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (timeout) begin
        frame_error <= 1'b1;
        state       <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          STOP: begin
            // Odd parity over data plus parity bit, and stop bit must be high.
            if (data_s2 && (^{shreg, par_bit})) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
